// File: rtl/seg_value_encoder_pkg.sv
// seg_value_encoder_pkg: FSM codes and display constants shared by the encoder slice
package seg_value_encoder_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  localparam logic [3:0] BLANK_CODE = 4'hF;
  localparam int DIGIT_N = 6;
  localparam int MAX_VAL = 999999;
endpackage

// File: rtl/seg_value_encoder_bcd_add3.sv
// bcd_add3: double-dabble digit correction, adds 3 to a BCD digit of 5 or more
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/seg_value_encoder.sv
// seg_value_encoder: fixed-latency binary to six-digit BCD with leading-zero blanking and overflow clamp
module seg_value_encoder
  import seg_value_encoder_pkg::*;
#(
  parameter int BIN_W = 20,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [BIN_W-1:0] bin_in,
  output logic             busy,
  output logic             done,
  output logic [24:0]      seg_value
);
  localparam int CW = $clog2(BIN_W + 1);
  localparam int EW = BIN_W > 20 ? BIN_W : 20;
  logic [1:0] state;
  logic [BIN_W-1:0] bin_q;
  logic [23:0] bcd, bcd_adj, bcd_blank;
  logic [CW-1:0] cnt;
  logic ovf, lead;
  for (genvar i = 0; i < DIGIT_N; i++) begin : g_add
    bcd_add3 u_add (.d(bcd[4*i+:4]), .q(bcd_adj[4*i+:4]));
  end
  // overflow clamps to all nines, so it never has leading zeros to blank
  always_comb begin
    bcd_blank = ovf ? 24'h999999 : bcd;
    lead = BLANK_LZ;
    for (int k = DIGIT_N - 1; k > 0; k--) begin
      lead = lead && bcd_blank[4*k+:4] == 4'd0;
      bcd_blank[4*k+:4] = lead ? BLANK_CODE : bcd_blank[4*k+:4];
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      bin_q <= '0;
      bcd <= '0;
      cnt <= '0;
      ovf <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      seg_value <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          bin_q <= bin_in;
          bcd <= '0;
          cnt <= '0;
          ovf <= EW'(bin_in) > EW'(MAX_VAL);
          busy <= 1'b1;
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          {bcd, bin_q} <= {bcd_adj[22:0], bin_q, 1'b0};
          cnt <= cnt + 1'b1;
          state <= cnt == CW'(BIN_W - 1) ? S_BLANK : S_SHIFT;
        end
        S_BLANK: begin
          bcd <= bcd_blank;
          state <= S_DONE;
        end
        default: begin
          seg_value <= {ovf, bcd};
          done <= 1'b1;
          busy <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule
